// File: rtl/fault_campaign_ctrl_pkg.sv
// Shared types for the fault-injection campaign controller: FSM states,
// fault classes and the saturating result counters.
package fsim_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_INJECT,
    ST_OBSERVE,
    ST_REPORT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_ND = 2'd0,
    CLS_ON = 2'd1,
    CLS_PN = 2'd2
  } fclass_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fault_campaign_ctrl_if.sv
// Observation bus: fault-free reference, injected-copy outputs and their X flags.
interface fault_campaign_ctrl_if #(
  parameter int OBS_W = 32
);
  logic [OBS_W-1:0] golden;
  logic [OBS_W-1:0] faulty;
  logic [OBS_W-1:0] faulty_x;

  modport master (output golden, faulty, faulty_x);
  modport slave  (input  golden, faulty, faulty_x);
endinterface

// File: rtl/fault_classifier.sv
// Per-cycle comparison of the injected copy against the reference:
// a definite difference (ON hit) or any unknown bit (X hit).
module fault_classifier #(
  parameter int OBS_W = 32
) (
  fault_campaign_ctrl_if.slave obs,
  output logic                 on_hit,
  output logic                 x_hit
);

  logic [OBS_W-1:0] on_bits;

  // An X bit can never count as a real mismatch, whatever its value.
  for (genvar gi = 0; gi < OBS_W; gi++) begin : g_bit
    assign on_bits[gi] = (obs.golden[gi] ^ obs.faulty[gi]) & ~obs.faulty_x[gi];
  end

  assign on_hit = |on_bits;
  assign x_hit  = |obs.faulty_x;
endmodule

// File: rtl/fault_campaign_ctrl.sv
// Sequences a stuck-at campaign over every site (SA0 then SA1), classifies
// each fault as ND/ON/PN and hands results out over a valid/ready port.
module fault_campaign_ctrl
  import fsim_pkg::*;
#(
  parameter int  NUM_SITES = 16,
  parameter int  OBS_W     = 32,
  parameter int  WINDOW    = 8,
  localparam int SITE_W    = (NUM_SITES > 1) ? $clog2(NUM_SITES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [OBS_W-1:0]  golden_i,
  input  logic [OBS_W-1:0]  faulty_i,
  input  logic [OBS_W-1:0]  faulty_x_i,
  output logic              inj_en_o,
  output logic [SITE_W-1:0] inj_site_o,
  output logic              inj_val_o,
  output logic              dut_rst_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [SITE_W-1:0] res_site_o,
  output logic              res_val_o,
  output logic [1:0]        res_class_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  on_cnt_o,
  output logic [CNT_W-1:0]  pn_cnt_o,
  output logic [CNT_W-1:0]  nd_cnt_o
);

  fault_campaign_ctrl_if #(.OBS_W(OBS_W)) obs_bus ();

  assign obs_bus.golden   = golden_i;
  assign obs_bus.faulty   = faulty_i;
  assign obs_bus.faulty_x = faulty_x_i;

  logic on_hit;
  logic x_hit;

  fault_classifier #(.OBS_W(OBS_W)) u_classifier (
    .obs    (obs_bus.slave),
    .on_hit (on_hit),
    .x_hit  (x_hit)
  );

  state_t            state_reg;
  logic [SITE_W-1:0] site_reg;
  logic              val_reg;
  logic [7:0]        obs_cnt_reg;
  logic              pn_flag_reg;
  fclass_t           cls_reg;
  logic [CNT_W-1:0]  on_cnt_reg, pn_cnt_reg, nd_cnt_reg;
  logic              inj_en_reg, dut_rst_reg, res_valid_reg, busy_reg, done_reg;
  logic              last_fault;

  assign last_fault = (site_reg == SITE_W'(NUM_SITES - 1)) && val_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      site_reg      <= '0;
      val_reg       <= 1'b0;
      obs_cnt_reg   <= '0;
      pn_flag_reg   <= 1'b0;
      cls_reg       <= CLS_ND;
      on_cnt_reg    <= '0;
      pn_cnt_reg    <= '0;
      nd_cnt_reg    <= '0;
      inj_en_reg    <= 1'b0;
      dut_rst_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else if (abort_i && state_reg != ST_IDLE) begin
      // Abort wins over a same-cycle handshake: the pending result is dropped.
      state_reg     <= ST_IDLE;
      pn_flag_reg   <= 1'b0;
      inj_en_reg    <= 1'b0;
      dut_rst_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg   <= ST_SETUP;
            site_reg    <= '0;
            val_reg     <= 1'b0;
            pn_flag_reg <= 1'b0;
            on_cnt_reg  <= '0;
            pn_cnt_reg  <= '0;
            nd_cnt_reg  <= '0;
            busy_reg    <= 1'b1;
            dut_rst_reg <= 1'b1;
          end
        end
        ST_SETUP: begin
          state_reg   <= ST_INJECT;
          dut_rst_reg <= 1'b0;
          inj_en_reg  <= 1'b1;
        end
        ST_INJECT: begin
          state_reg   <= ST_OBSERVE;
          obs_cnt_reg <= '0;
        end
        ST_OBSERVE: begin
          if (on_hit) begin
            cls_reg       <= CLS_ON;
            state_reg     <= ST_REPORT;
            inj_en_reg    <= 1'b0;
            res_valid_reg <= 1'b1;
          end else begin
            if (x_hit) pn_flag_reg <= 1'b1;
            if (obs_cnt_reg == 8'(WINDOW - 1)) begin
              cls_reg       <= (pn_flag_reg || x_hit) ? CLS_PN : CLS_ND;
              state_reg     <= ST_REPORT;
              inj_en_reg    <= 1'b0;
              res_valid_reg <= 1'b1;
            end else begin
              obs_cnt_reg <= obs_cnt_reg + 8'd1;
            end
          end
        end
        ST_REPORT: begin
          if (res_ready_i) begin
            res_valid_reg <= 1'b0;
            pn_flag_reg   <= 1'b0;
            case (cls_reg)
              CLS_ON:  on_cnt_reg <= sat_inc(on_cnt_reg);
              CLS_PN:  pn_cnt_reg <= sat_inc(pn_cnt_reg);
              default: nd_cnt_reg <= sat_inc(nd_cnt_reg);
            endcase
            if (last_fault) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= ST_SETUP;
              dut_rst_reg <= 1'b1;
              if (val_reg) begin
                site_reg <= site_reg + SITE_W'(1);
                val_reg  <= 1'b0;
              end else begin
                val_reg <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign inj_en_o    = inj_en_reg;
  assign inj_site_o  = site_reg;
  assign inj_val_o   = val_reg;
  assign dut_rst_o   = dut_rst_reg;
  assign res_valid_o = res_valid_reg;
  assign res_site_o  = site_reg;
  assign res_val_o   = val_reg;
  assign res_class_o = cls_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign on_cnt_o    = on_cnt_reg;
  assign pn_cnt_o    = pn_cnt_reg;
  assign nd_cnt_o    = nd_cnt_reg;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Campaign-level bench: per-fault expectations queued at start, popped and
// compared on each result handshake; counters tracked every cycle.
module tb_fault_campaign_ctrl;
  import fsim_pkg::*;

  localparam int NS  = 2;
  localparam int OW  = 8;
  localparam int WIN = 4;
  localparam int SW  = 1;
  localparam int NF  = 2 * NS;

  typedef struct {
    logic [SW-1:0] site;
    logic          val;
    logic [1:0]    cls;
    int            obs;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic inj_en_o, inj_val_o, dut_rst_o, res_valid_o, res_val_o, busy_o, done_o;
  logic [SW-1:0] inj_site_o, res_site_o;
  logic [1:0]    res_class_o;
  logic [15:0]   on_cnt_o, pn_cnt_o, nd_cnt_o;

  fault_campaign_ctrl_if #(.OBS_W(OW)) obs ();

  fault_campaign_ctrl #(.NUM_SITES(NS), .OBS_W(OW), .WINDOW(WIN)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .golden_i(obs.golden), .faulty_i(obs.faulty), .faulty_x_i(obs.faulty_x),
    .inj_en_o(inj_en_o), .inj_site_o(inj_site_o), .inj_val_o(inj_val_o),
    .dut_rst_o(dut_rst_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready),
    .res_site_o(res_site_o), .res_val_o(res_val_o), .res_class_o(res_class_o),
    .busy_o(busy_o), .done_o(done_o),
    .on_cnt_o(on_cnt_o), .pn_cnt_o(pn_cnt_o), .nd_cnt_o(nd_cnt_o)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   x_cyc[NF], on_cyc[NF];
  bit   stall_f[NF];
  int   abort_obs_f = -1, abort_obs_n = 0, abort_rep_f = -1;
  int   n_checks = 0, n_pass = 0;
  int   obs_n = 0, stall_left = 0, m_on = 0, m_pn = 0, m_nd = 0, done_cnt = 0, drst_cnt = 0;
  bit   inj_prev = 0, in_res = 0, aborted = 0;
  logic [SW-1:0] cap_site;
  logic          cap_val;
  logic [1:0]    cap_cls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_scn();
    for (int f = 0; f < NF; f++) begin
      x_cyc[f] = 0; on_cyc[f] = 0; stall_f[f] = 0;
    end
    abort_obs_f = -1; abort_obs_n = 0; abort_rep_f = -1;
  endtask

  task automatic push_expect();
    exp_t e;
    for (int f = 0; f < NF; f++) begin
      e.site = SW'(f / 2);
      e.val  = (f % 2) == 1;
      if (on_cyc[f] >= 1 && on_cyc[f] <= WIN) begin
        e.cls = CLS_ON; e.obs = on_cyc[f];
      end else if (x_cyc[f] >= 1 && x_cyc[f] <= WIN) begin
        e.cls = CLS_PN; e.obs = WIN;
      end else begin
        e.cls = CLS_ND; e.obs = WIN;
      end
      sb.push_back(e);
    end
  endtask

  // One clock: compare counters, drive observation data, service the result port.
  task automatic tick();
    int f;
    exp_t e;
    logic [OW-1:0] mask;
    @(negedge clk);
    abort = 1'b0;
    chk("on_cnt", on_cnt_o, m_on);
    chk("pn_cnt", pn_cnt_o, m_pn);
    chk("nd_cnt", nd_cnt_o, m_nd);
    f = int'({inj_site_o, inj_val_o});
    mask = '0;
    obs.faulty_x = '0;
    obs.golden = OW'($urandom);
    if (inj_en_o && !inj_prev) obs_n = 0;
    else if (inj_en_o) begin
      obs_n++;
      if (on_cyc[f] == obs_n) mask = OW'(8);
      if (x_cyc[f] == obs_n) begin
        obs.faulty_x = OW'(1);
        mask[0] = 1'b1;
      end
      if (abort_obs_f == f && abort_obs_n == obs_n) begin
        abort = 1'b1; aborted = 1;
      end
    end
    obs.faulty = obs.golden ^ mask;
    inj_prev = inj_en_o;
    if (dut_rst_o) drst_cnt++;
    if (done_o) done_cnt++;
    if (res_valid_o) begin
      if (!in_res) begin
        in_res = 1; cap_site = res_site_o; cap_val = res_val_o; cap_cls = res_class_o;
        stall_left = stall_f[f] ? 5 : 0;
      end else begin
        chk("stall_site", res_site_o, cap_site);
        chk("stall_val", res_val_o, cap_val);
        chk("stall_class", res_class_o, cap_cls);
      end
      if (stall_left > 0) begin
        res_ready = 1'b0; stall_left--;
      end else begin
        res_ready = 1'b1; in_res = 0;
        if (abort_rep_f == f) begin
          abort = 1'b1; aborted = 1;
        end else if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("result site=%0d val=%0d class=%0d obs=%0d", res_site_o, res_val_o, res_class_o, obs_n);
          chk("res_site", res_site_o, e.site);
          chk("res_val", res_val_o, e.val);
          chk("res_class", res_class_o, e.cls);
          chk("obs_cycles", obs_n, e.obs);
          if (e.cls == CLS_ON) m_on++;
          else if (e.cls == CLS_PN) m_pn++;
          else m_nd++;
        end
      end
    end
  endtask

  task automatic run_campaign(input bit expect_abort, input int left);
    int n;
    push_expect();
    m_on = 0; m_pn = 0; m_nd = 0; done_cnt = 0; drst_cnt = 0;
    aborted = 0; in_res = 0; stall_left = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!aborted && done_cnt == 0 && n < 400) begin
      tick();
      n++;
      start = (n == 20);
    end
    start = 1'b0;
    if (n >= 400) chk("campaign_timeout", 0, 1);
    tick();
    chk("busy_after", busy_o, 0);
    chk("inj_en_after", inj_en_o, 0);
    if (expect_abort) begin
      repeat (3) tick();
      chk("abort_dropped", sb.size(), left);
      chk("abort_no_done", done_cnt, 0);
      sb.delete();
    end else begin
      chk("done_pulses", done_cnt, 1);
      chk("sb_empty", sb.size(), 0);
      chk("dut_rst_pulses", drst_cnt, NF);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    obs.golden = '0; obs.faulty = '0; obs.faulty_x = '0;
    clear_scn();
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_inj_en", inj_en_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_dut_rst", dut_rst_o, 0);
    rst = 1'b0;
    tick();

    clear_scn();
    run_campaign(0, 0);
    chk("all_nd_count", nd_cnt_o, 4);

    clear_scn();
    x_cyc[0] = 1; x_cyc[1] = WIN; stall_f[2] = 1; on_cyc[3] = 2;
    run_campaign(0, 0);
    chk("mix_on", on_cnt_o, 1);
    chk("mix_pn", pn_cnt_o, 2);
    chk("mix_nd", nd_cnt_o, 1);

    clear_scn();
    x_cyc[0] = 1; on_cyc[0] = 3; on_cyc[1] = 1; abort_obs_f = 2; abort_obs_n = 2;
    run_campaign(1, 2);
    chk("abort_obs_on", on_cnt_o, 2);
    chk("abort_obs_nd", nd_cnt_o, 0);

    clear_scn();
    stall_f[0] = 1; abort_rep_f = 0;
    run_campaign(1, 4);
    chk("abort_rep_nd", nd_cnt_o, 0);

    // Asynchronous reset while fault 1 is in INJECT.
    clear_scn();
    push_expect();
    m_on = 0; m_pn = 0; m_nd = 0; in_res = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(inj_en_o && obs_n == 0 && inj_val_o) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("inject_timeout", 0, 1);
    chk("pre_rst_nd", nd_cnt_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_inj_en", inj_en_o, 0);
    chk("arst_inj_val", inj_val_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_nd_cnt", nd_cnt_o, 0);
    chk("arst_outputs", {dut_rst_o, res_valid_o, done_o, res_class_o, on_cnt_o, pn_cnt_o}, 0);
    m_nd = 0;
    sb.delete();
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fault_campaign_ctrl.md
FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SITES, default 16, meaning number of injectable fault sites.
REQ-002 The block SHALL have parameter OBS_W, default 32, meaning width of the observed output bus.
REQ-003 The block SHALL have parameter WINDOW, default 8, meaning observation cycles per fault (range 1..255).
REQ-004 The block SHALL use one clock and asynchronous active-high reset, with the ports listed next.
REQ-005 clk_i  in  1  clock; all state changes on rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 start_i  in  1  begin campaign; sampled only in IDLE.
REQ-008 abort_i  in  1  terminate campaign; checked in every non-IDLE state.
REQ-009 golden_i  in  OBS_W  fault-free reference outputs.
REQ-010 faulty_i  in  OBS_W  outputs of the injected copy.
REQ-011 faulty_x_i  in  OBS_W  per-bit unknown (X) flag on faulty_i.
REQ-012 inj_en_o  out  1  force-enable to the injected copy.
REQ-013 inj_site_o  out  $clog2(NUM_SITES)  active fault site index.
REQ-014 inj_val_o  out  1  stuck-at value (0 = SA0, 1 = SA1).
REQ-015 dut_rst_o  out  1  one-cycle reset pulse to the injected copy.
REQ-016 res_valid_o / res_ready_i  out/in  1/1  result handshake.
REQ-017 res_site_o, res_val_o, res_class_o  out  $clog2(NUM_SITES)/1/2  result payload; class ND=0, ON=1, PN=2.
REQ-018 busy_o, done_o  out  1/1  campaign active; one-cycle completion pulse.
REQ-019 on_cnt_o, pn_cnt_o, nd_cnt_o  out  16 each  saturating class counters.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, INJECT, OBSERVE, REPORT, DONE.
REQ-021 IDLE->SETUP on start_i; fault index, all counters, and sticky PN flag SHALL be cleared in that same transition.
REQ-022 SETUP SHALL last exactly 1 cycle, asserting dut_rst_o, and SHALL go to INJECT.
REQ-023 INJECT SHALL last 1 cycle with inj_en_o=1; inj_en_o SHALL stay 1 through OBSERVE and SHALL be 0 in all other states.
REQ-024 Fault order SHALL be site 0 SA0, site 0 SA1, site 1 SA0, ..., i.e. 2*NUM_SITES faults.
REQ-025 In OBSERVE, each cycle: any bit with golden_i!=faulty_i and faulty_x_i=0 SHALL classify ON and leave OBSERVE next cycle (early drop).
REQ-026 In OBSERVE, any bit with faulty_x_i=1 and no ON hit that cycle SHALL set the sticky PN flag; ON in a later cycle SHALL override PN.
REQ-027 OBSERVE SHALL exit after WINDOW cycles unless dropped earlier; the class is then PN if the flag is set, else ND.
REQ-028 REPORT SHALL hold res_valid_o=1 with stable payload until res_valid_o&&res_ready_i; the matching counter SHALL increment on that handshake cycle, saturating at 16'hFFFF.
REQ-029 After the handshake, the PN flag SHALL clear; the next fault SHALL go to SETUP, and the last fault (site NUM_SITES-1, SA1) SHALL go to DONE.
REQ-030 DONE SHALL pulse done_o for 1 cycle and return to IDLE; busy_o SHALL be 1 in every state except IDLE.
REQ-031 abort_i SHALL force IDLE next cycle from any state, dropping any pending result without counting it; abort_i SHALL take priority over the REPORT handshake in the same cycle; done_o SHALL NOT pulse; counters SHALL hold.
REQ-032 start_i asserted outside IDLE SHALL be ignored.

Reset
REQ-033 On rst_i, state SHALL be IDLE and every output SHALL be 0, including counters; reset mid-campaign SHALL discard progress, releasing inj_en_o immediately (asynchronous).

Structure
REQ-034 Package fsim_pkg SHALL hold the state enum, the fault-class enum (ND/ON/PN), and the counter width constant.
REQ-035 Sub-module fault_classifier (combinational ON-hit / X-hit detection on OBS_W bits) SHALL be used; all sequencing SHALL stay in the top.

Verification
REQ-036 NUM_SITES=2, WINDOW=4, faulty_i==golden_i, faulty_x_i=0, res_ready_i=1 -> 4 results, all ND, nd_cnt_o=4, done_o pulses once.
REQ-037 Site 1 SA1: faulty_i differs in bit 3 in the 2nd OBSERVE cycle -> ON reported after 2 observe cycles, on_cnt_o=1.
REQ-038 Site 0 SA0: faulty_x_i[0]=1 in cycle 1, then clean -> PN at window end; same with a real mismatch in cycle 3 -> ON.
REQ-039 res_ready_i held 0 for 5 cycles in REPORT -> payload stable, counter increments only on the accepting cycle.
REQ-040 abort_i during OBSERVE of fault 2 -> IDLE next cycle, inj_en_o=0, counters unchanged, no done_o; rst_i mid-INJECT -> all outputs 0 asynchronously.
